// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller.
//   pipe_state_e : controller FSM states
//   pipe_ctl_t   : bundle of stall/flush/redirect flags driven to the pipeline
package pipe_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] ZERO_WORD     = '0;
  localparam logic            WRITE_DISABLE = 1'b0;

  typedef enum logic {
    PIPE_IDLE     = 1'b0,
    PIPE_INT_HOLD = 1'b1
  } pipe_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic jump;
  } pipe_ctl_t;

  localparam pipe_ctl_t CTL_NONE = '{default: WRITE_DISABLE};

  // Redirect: pc loads a new target, both younger stages are squashed.
  function automatic pipe_ctl_t ctl_redirect();
    pipe_ctl_t c;
    c             = CTL_NONE;
    c.jump        = 1'b1;
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

  // Bubble: front end holds, id_ex receives a NOP.
  function automatic pipe_ctl_t ctl_bubble();
    pipe_ctl_t c;
    c             = CTL_NONE;
    c.pc_stall    = 1'b1;
    c.if_id_stall = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

  // Drain: pc runs, both pipeline registers load NOPs.
  function automatic pipe_ctl_t ctl_drain();
    pipe_ctl_t c;
    c             = CTL_NONE;
    c.if_id_flush = 1'b1;
    c.id_ex_flush = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_wdt.sv
// Stall watchdog: counts consecutive stall cycles (saturating) and raises a
// sticky timeout once a stall continues past WDT_LIMIT cycles.
//   clk, rst   : clock, synchronous active-high reset
//   stall_i    : pc is stalled this cycle
//   timeout_o  : sticky, registered; cleared only by rst
module stall_wdt
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned WDT_LIMIT = 255,
  parameter int unsigned WDT_W     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic stall_i,
  output logic timeout_o
);

  logic [WDT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  // Next-state: saturating increment while stalled, clear otherwise.
  always_comb begin
    cnt_d     = '0;
    timeout_d = timeout_q;
    if (stall_i) begin
      cnt_d = (cnt_q == {WDT_W{1'b1}}) ? cnt_q : cnt_q + WDT_W'(1);
      if (cnt_q == WDT_W'(WDT_LIMIT)) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      timeout_q <= WRITE_DISABLE;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Central pipeline controller for the pc -> if_id -> id_ex -> ex core.
// Arbitrates interrupt, jump, multi-cycle-unit and load-use requests and
// drives stall/flush/redirect flags with zero latency from state + inputs.
//   clk, rst          : clock, synchronous active-high reset
//   jump_flag_i/addr  : taken branch/jump from ex (pulse)
//   int_assert_i/addr : interrupt entry from clint (pulse)
//   div_busy_i        : multi-cycle unit busy (level)
//   load_use_i        : load-use hazard from id (level)
//   pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o : pipeline control
//   jump_flag_o/jump_addr_o : pc redirect (addr is 0 when flag is 0)
//   stall_timeout_o   : sticky stall watchdog flag (registered)
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned INT_HOLD_CYC = 2,
  parameter int unsigned WDT_LIMIT    = 255,
  parameter int unsigned WDT_W        = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            jump_flag_i,
  input  logic [XLEN-1:0] jump_addr_i,
  input  logic            int_assert_i,
  input  logic [XLEN-1:0] int_addr_i,
  input  logic            div_busy_i,
  input  logic            load_use_i,
  output logic            pc_stall_o,
  output logic            if_id_stall_o,
  output logic            if_id_flush_o,
  output logic            id_ex_flush_o,
  output logic            jump_flag_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            stall_timeout_o
);

  localparam int unsigned HOLD_W = (INT_HOLD_CYC > 1) ? $clog2(INT_HOLD_CYC) : 1;

  pipe_state_e       state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  pipe_ctl_t         ctl;
  logic [XLEN-1:0]   jump_addr;

  // State register and interrupt hold counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PIPE_IDLE;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  // Next state, priority arbitration and flag decode.
  // Outputs are forced quiet while rst is high so the pipeline sees no
  // spurious redirect in the reset cycle itself.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    ctl        = CTL_NONE;
    jump_addr  = ZERO_WORD;
    if (!rst) begin
      unique case (state_q)
        PIPE_IDLE: begin
          if (int_assert_i) begin
            // A jump in the same cycle is dropped: the trap vector wins.
            ctl        = ctl_redirect();
            jump_addr  = int_addr_i;
            state_d    = PIPE_INT_HOLD;
            hold_cnt_d = HOLD_W'(INT_HOLD_CYC - 1);
          end else if (jump_flag_i) begin
            ctl       = ctl_redirect();
            jump_addr = jump_addr_i;
          end else if (div_busy_i || load_use_i) begin
            ctl = ctl_bubble();
          end
        end
        PIPE_INT_HOLD: begin
          // Trap entry drains the pipe; every other request is ignored.
          ctl = ctl_drain();
          if (hold_cnt_q == '0) begin
            state_d = PIPE_IDLE;
          end else begin
            hold_cnt_d = hold_cnt_q - HOLD_W'(1);
          end
        end
        default: begin
          state_d    = PIPE_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
    // if_id cannot hold and squash at once; squash wins.
    if (ctl.if_id_flush) begin
      ctl.if_id_stall = 1'b0;
    end
  end

  assign pc_stall_o    = ctl.pc_stall;
  assign if_id_stall_o = ctl.if_id_stall;
  assign if_id_flush_o = ctl.if_id_flush;
  assign id_ex_flush_o = ctl.id_ex_flush;
  assign jump_flag_o   = ctl.jump;
  assign jump_addr_o   = jump_addr;

  stall_wdt #(
    .WDT_LIMIT (WDT_LIMIT),
    .WDT_W     (WDT_W)
  ) u_stall_wdt (
    .clk       (clk),
    .rst       (rst),
    .stall_i   (ctl.pc_stall),
    .timeout_o (stall_timeout_o)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random stimulus against a behavioural model.
module tb_pipe_ctrl;

  localparam int unsigned HOLD = 2;
  localparam int unsigned LIM  = 3;
  localparam int          NRND = 3000;

  typedef struct packed {
    logic        rst;
    logic        jf;
    logic [31:0] ja;
    logic        ia;
    logic [31:0] iaddr;
    logic        busy;
    logic        lu;
  } in_t;

  // fl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, jump_flag}
  typedef struct packed {
    logic [4:0]  fl;
    logic [31:0] addr;
    logic        to;
  } out_t;

  typedef struct {
    logic chk;
    in_t  i;
    out_t e;
  } vec_t;

  localparam logic [4:0] F_NONE   = 5'b00000;
  localparam logic [4:0] F_JUMP   = 5'b00111;
  localparam logic [4:0] F_DRAIN  = 5'b00110;
  localparam logic [4:0] F_BUBBLE = 5'b11010;

  logic        clk = 1'b0;
  logic        rst, jump_flag_i, int_assert_i, div_busy_i, load_use_i;
  logic [31:0] jump_addr_i, int_addr_i, jump_addr_o;
  logic        pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o;
  logic        jump_flag_o, stall_timeout_o;

  int vectors    = 0;
  int miscompares = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_ctrl #(
    .INT_HOLD_CYC (HOLD),
    .WDT_LIMIT    (LIM),
    .WDT_W        (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .jump_flag_i     (jump_flag_i),
    .jump_addr_i     (jump_addr_i),
    .int_assert_i    (int_assert_i),
    .int_addr_i      (int_addr_i),
    .div_busy_i      (div_busy_i),
    .load_use_i      (load_use_i),
    .pc_stall_o      (pc_stall_o),
    .if_id_stall_o   (if_id_stall_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_ex_flush_o   (id_ex_flush_o),
    .jump_flag_o     (jump_flag_o),
    .jump_addr_o     (jump_addr_o),
    .stall_timeout_o (stall_timeout_o)
  );

  function automatic in_t mk_in(logic r, logic jf, logic [31:0] ja, logic ia,
                                logic [31:0] iaddr, logic busy, logic lu);
    in_t x;
    x.rst = r; x.jf = jf; x.ja = ja; x.ia = ia;
    x.iaddr = iaddr; x.busy = busy; x.lu = lu;
    return x;
  endfunction

  function automatic out_t mk_out(logic [4:0] fl, logic [31:0] addr, logic to);
    out_t x;
    x.fl = fl; x.addr = addr; x.to = to;
    return x;
  endfunction

  task automatic add(input logic chk, input in_t i, input out_t e);
    vec_t v;
    v.chk = chk; v.i = i; v.e = e;
    tbl.push_back(v);
  endtask

  // One clock cycle: drive after the edge, check at the falling edge.
  task automatic cyc(input in_t i, input logic chk, input out_t e, input string nm);
    out_t a;
    rst = i.rst; jump_flag_i = i.jf; jump_addr_i = i.ja;
    int_assert_i = i.ia; int_addr_i = i.iaddr;
    div_busy_i = i.busy; load_use_i = i.lu;
    @(negedge clk);
    a.fl   = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, jump_flag_o};
    a.addr = jump_addr_o;
    a.to   = stall_timeout_o;
    if (chk) begin
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL %s: got flags=%b addr=%h timeout=%b, want flags=%b addr=%h timeout=%b",
                 nm, a.fl, a.addr, a.to, e.fl, e.addr, e.to);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: remaining trap-drain cycles, length of current stall run.
  int   m_drain_left = 0;
  int   m_run        = 0;
  logic m_to         = 1'b0;

  function automatic out_t model_out(in_t i);
    out_t o;
    o = mk_out(F_NONE, 32'h0, m_to);
    if (!i.rst) begin
      if (m_drain_left > 0)       o.fl = F_DRAIN;
      else if (i.ia)              begin o.fl = F_JUMP; o.addr = i.iaddr; end
      else if (i.jf)              begin o.fl = F_JUMP; o.addr = i.ja; end
      else if (i.busy || i.lu)    o.fl = F_BUBBLE;
    end
    return o;
  endfunction

  task automatic model_step(in_t i, out_t o);
    if (i.rst) begin
      m_drain_left = 0; m_run = 0; m_to = 1'b0;
    end else begin
      if (m_drain_left > 0) m_drain_left--;
      else if (i.ia)        m_drain_left = HOLD;
      if (o.fl[4]) begin
        if (m_run >= LIM) m_to = 1'b1;
        m_run++;
      end else begin
        m_run = 0;
      end
    end
  endtask

  initial begin
    in_t  ri;
    out_t ro;
    rst = 1'b1; jump_flag_i = 0; jump_addr_i = 0; int_assert_i = 0;
    int_addr_i = 0; div_busy_i = 0; load_use_i = 0;
    @(posedge clk);
    #1;

    // Directed table: reset, jump, interrupt + hold, div/load-use, priority.
    add(0, mk_in(1, 1, 32'h55, 1, 32'h66, 1, 1), mk_out(F_NONE, 0, 0));
    add(1, mk_in(1, 1, 32'h77, 0, 32'h0,  1, 1), mk_out(F_NONE, 0, 0));
    add(1, mk_in(0, 0, 32'h0,  0, 32'h0,  0, 0), mk_out(F_NONE, 0, 0));
    add(1, mk_in(0, 1, 32'h100,0, 32'h0,  0, 0), mk_out(F_JUMP, 32'h100, 0));
    add(1, mk_in(0, 0, 32'h100,0, 32'h0,  0, 0), mk_out(F_NONE, 0, 0));
    add(1, mk_in(0, 1, 32'h200,1, 32'h80, 0, 0), mk_out(F_JUMP, 32'h80, 0));
    add(1, mk_in(0, 1, 32'h300,0, 32'h0,  0, 0), mk_out(F_DRAIN, 0, 0));
    add(1, mk_in(0, 0, 32'h0,  1, 32'h90, 1, 1), mk_out(F_DRAIN, 0, 0));
    add(1, mk_in(0, 0, 32'h0,  0, 32'h0,  0, 0), mk_out(F_NONE, 0, 0));
    for (int k = 1; k <= 5; k++)
      add(1, mk_in(0, 0, 32'h0, 0, 32'h0, 1, 1), mk_out(F_BUBBLE, 0, k >= 5));
    add(1, mk_in(0, 0, 32'h0,  0, 32'h0,  0, 0), mk_out(F_NONE, 0, 1));
    add(1, mk_in(1, 0, 32'h0,  0, 32'h0,  1, 0), mk_out(F_NONE, 0, 1));
    add(1, mk_in(1, 0, 32'h0,  0, 32'h0,  0, 0), mk_out(F_NONE, 0, 0));
    add(1, mk_in(0, 0, 32'h0,  0, 32'h0,  0, 1), mk_out(F_BUBBLE, 0, 0));
    add(1, mk_in(0, 0, 32'h0,  0, 32'h0,  0, 0), mk_out(F_NONE, 0, 0));
    add(1, mk_in(0, 1, 32'h44, 0, 32'h0,  1, 1), mk_out(F_JUMP, 32'h44, 0));
    add(1, mk_in(0, 0, 32'h0,  0, 32'h0,  1, 0), mk_out(F_BUBBLE, 0, 0));
    add(1, mk_in(0, 0, 32'h0,  0, 32'h0,  0, 0), mk_out(F_NONE, 0, 0));

    foreach (tbl[n])
      cyc(tbl[n].i, tbl[n].chk, tbl[n].e, $sformatf("tbl%0d", n));

    // Watchdog: busy held 10 cycles, timeout visible from the 5th, sticky after.
    for (int k = 1; k <= 10; k++)
      cyc(mk_in(0, 0, 0, 0, 0, 1, 0), 1, mk_out(F_BUBBLE, 0, k >= 5),
          $sformatf("wdt_busy%0d", k));
    for (int k = 1; k <= 3; k++)
      cyc(mk_in(0, 0, 0, 0, 0, 0, 0), 1, mk_out(F_NONE, 0, 1),
          $sformatf("wdt_sticky%0d", k));
    cyc(mk_in(1, 0, 0, 0, 0, 0, 0), 1, mk_out(F_NONE, 0, 1), "wdt_rst_edge");
    cyc(mk_in(0, 0, 0, 0, 0, 0, 0), 1, mk_out(F_NONE, 0, 0), "wdt_cleared");

    // Reset in the 2nd hold cycle returns the FSM to idle.
    cyc(mk_in(0, 0, 0, 1, 32'h80, 0, 0), 1, mk_out(F_JUMP, 32'h80, 0), "rh_entry");
    cyc(mk_in(0, 0, 0, 0, 0, 0, 0),      1, mk_out(F_DRAIN, 0, 0),     "rh_hold1");
    cyc(mk_in(1, 1, 32'h9, 0, 0, 1, 0),  1, mk_out(F_NONE, 0, 0),      "rh_rst");
    cyc(mk_in(0, 1, 32'h40, 0, 0, 0, 0), 1, mk_out(F_JUMP, 32'h40, 0), "rh_idle_jump");
    cyc(mk_in(1, 0, 0, 0, 0, 0, 0),      1, mk_out(F_NONE, 0, 0),      "rh_final_rst");

    // Random stimulus against the model (model starts from reset state).
    m_drain_left = 0; m_run = 0; m_to = 1'b0;
    for (int n = 0; n < NRND; n++) begin
      ri = mk_in($urandom_range(63) == 0,
                 $urandom_range(5) == 0, $urandom,
                 $urandom_range(15) == 0, $urandom,
                 $urandom_range(3) == 0, $urandom_range(3) == 0);
      ro = model_out(ri);
      cyc(ri, 1, ro, $sformatf("rnd%0d", n));
      model_step(ri, ro);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
